// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: first-word fall-through FIFO of {pc, inst, adef} between fetch and decode.
// Optional macro PREDECODE_EN adds direct B/BL pre-decode with a one-cycle fetch redirect.
module inst_fetch_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic             in_adef,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_adef,
  output logic [PTR_W:0]   count,
  output logic             pd_redirect,
  output logic [31:0]      pd_target
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } entry_t;

  localparam logic [31:0]    NOP_INST = 32'h0340_0000;
  localparam logic [PTR_W:0] PTR_ONE  = (PTR_W + 1)'(1);

  entry_t         mem [DEPTH];
  entry_t         head;
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic           empty, full, push, pop;
  logic           redirect_block;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                     (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign in_ready  = !full && !redirect_block;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Head is gated so the decoder sees a harmless nop rather than stale storage.
  assign head     = mem[rd_ptr_q[PTR_W-1:0]];
  assign out_pc   = out_valid ? head.pc   : 32'h0;
  assign out_inst = out_valid ? head.inst : NOP_INST;
  assign out_adef = out_valid && head.adef;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= '{pc: in_pc, inst: in_inst, adef: in_adef};
    end
  end

`ifdef PREDECODE_EN
  logic        pd_redirect_q, pd_redirect_d;
  logic [31:0] pd_target_q, pd_target_d;
  logic [25:0] br_off;
  logic        is_direct_br;

  always_comb begin
    br_off        = {in_inst[9:0], in_inst[25:10]};
    is_direct_br  = ((in_inst[31:26] == 6'b010100) || (in_inst[31:26] == 6'b010101)) && !in_adef;
    pd_redirect_d = push && is_direct_br && !flush;
    pd_target_d   = pd_target_q;
    if (pd_redirect_d) pd_target_d = in_pc + {{4{br_off[25]}}, br_off, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pd_redirect_q <= 1'b0;
      pd_target_q   <= 32'h0;
    end else begin
      pd_redirect_q <= pd_redirect_d;
      pd_target_q   <= pd_target_d;
    end
  end

  // The word arriving during the redirect cycle is on the wrong path, so it is refused.
  assign redirect_block = pd_redirect_q;
  assign pd_redirect    = pd_redirect_q;
  assign pd_target      = pd_target_q;
`else
  assign redirect_block = 1'b0;
  assign pd_redirect    = 1'b0;
  assign pd_target      = 32'h0;
`endif

endmodule
